cache_access_arbiter: RTL and testbench
=======================================

# cache_access_arbiter

Front-end arbiter for one cache bank in the tiled cache network. It accepts read and write requests from the four router ports (NORTH, SOUTH, EAST, WEST), serialises writes onto the bank's single write port, and maps each port's reads to a dedicated bank read port (0=N, 1=S, 2=E, 3=W). Reads return with a ready strobe and the requester's network address so the router can route the response.

## Interface
- CACHE_BANK_ADDRESS_WIDTH, 8: bank word address width.
- NETWORK_ADDRESS_WIDTH, 6: requester node address width.
- DATA_WIDTH, 32: data word width.
- WR_FIFO_DEPTH, 4: per-port pending-write FIFO depth (power of two).

Ports (X ∈ NORTH, SOUTH, EAST, WEST):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cacheAddressIn_X  in  CACHE_BANK_ADDRESS_WIDTH  request bank address.
- requesterAddressIn_X  in  NETWORK_ADDRESS_WIDTH  requester node.
- memRead_X  in  1  read request, sampled every rising edge.
- memWrite_X  in  1  write request, sampled every rising edge.
- dataIn_X  in  DATA_WIDTH  write data.
- readReady_X  out  1  one-cycle strobe: bank read data for port X valid.
- requesterAddressOut_X  out  NETWORK_ADDRESS_WIDTH  requester of returned read.
- cacheDataIn  out  DATA_WIDTH  write data to bank.
- cacheWriteAddressIn  out  CACHE_BANK_ADDRESS_WIDTH  write address to bank.
- memWrite  out  1  bank write enable.
- memRead  out  1  bank read enable (OR of active read ports).
- cacheReadAddress_0..3  out  CACHE_BANK_ADDRESS_WIDTH  per-port read address (N,S,E,W).

## Operation
- Reset low: all outputs 0, all FIFOs emptied, arbitration pointer to NORTH. Reset asserted mid-operation discards pending writes and in-flight reads immediately.
- Write capture: memWrite_X high at an edge pushes {cacheAddressIn_X, dataIn_X} into port X's FIFO. Full FIFO: request silently dropped.
- Write arbitration: among non-empty FIFO heads, one grant per cycle; granted head popped and registered to cacheWriteAddressIn/cacheDataIn with memWrite=1 for exactly one cycle. No pending writes: memWrite=0, write address/data hold last value.
- Push and pop on same FIFO at the same edge allowed.
- Read: memRead_X high at an edge registers cacheReadAddress_i=cacheAddressIn_X and a per-port read-valid; requester address pipelined alongside. memRead = OR of read-valids. Address held when idle.
- Read response: one cycle after the read-valid cycle, readReady_X=1 for one cycle with requesterAddressOut_X = captured requester; requesterAddressOut_X holds until next response.
- All four ports may read in the same cycle; reads never stall.
- memRead_X and memWrite_X together: both processed independently.
- No read/write forwarding: a read of an address with a queued write returns bank contents as of the bank's read edge.

## Timing
- Write: request at edge k → memWrite high in cycle k..k+1 (registered at edge k+1... earliest: visible after edge k+1) when no contention; each additional contender adds one cycle.
- Read: request sampled at edge k → cacheReadAddress/memRead valid after edge k; readReady_X valid after edge k+1 (bank has one-cycle registered read).
- Sustained throughput: one write per cycle total, four reads per cycle.

## Configuration
- ARBITER_ROUND_ROBIN_EN defined: round-robin write grant; pointer advances to port after last granted, order N→S→E→W→N.
- Undefined: fixed priority NORTH > SOUTH > EAST > WEST.

## Test plan
- Reset held low with inputs toggling → every output 0; release → outputs stay 0 until a request.
- NORTH write data 10 addr 0x02 for one cycle → next cycle memWrite=1, cacheWriteAddressIn=0x02, cacheDataIn=10 for exactly one cycle.
- NORTH (5 @0x03) and SOUTH (4 @0x01) same cycle → two consecutive write cycles, 0x03/5 then 0x01/4; memWrite then drops.
- SOUTH (9 @0x09), EAST (6 @0x05), WEST (7 @0x04) same cycle, fixed priority → three consecutive writes 0x09, 0x05, 0x04; with ARBITER_ROUND_ROBIN_EN order starts from pointer after last grant.
- NORTH read addr 0x20 requester 3 and WEST read addr 0x40 requester 5 same cycle → next cycle cacheReadAddress_0=0x20, cacheReadAddress_3=0x40, memRead=1; following cycle readReady_NORTH=readReady_WEST=1 for one cycle, requesterAddressOut 3 and 5.
- Queue five WEST writes while NORTH writes every cycle (fixed priority) → WEST fifth write dropped; after NORTH stops, exactly four WEST writes issue in order; reset asserted mid-drain → memWrite=0 immediately, nothing further issued.

Source files
------------

// File: rtl/cache_access_arbiter.sv
// Cache bank front-end: per-port write FIFOs arbitrated onto one write port, four read ports.
// Define ARBITER_ROUND_ROBIN_EN for round-robin write grant; default is fixed N > S > E > W.
module cache_access_arbiter #(
  parameter int unsigned CACHE_BANK_ADDRESS_WIDTH = 8,
  parameter int unsigned NETWORK_ADDRESS_WIDTH    = 6,
  parameter int unsigned DATA_WIDTH               = 32,
  parameter int unsigned WR_FIFO_DEPTH            = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressIn_NORTH,
  input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressIn_SOUTH,
  input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressIn_EAST,
  input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressIn_WEST,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn_NORTH,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn_SOUTH,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn_EAST,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn_WEST,
  input  logic                                memRead_NORTH,
  input  logic                                memRead_SOUTH,
  input  logic                                memRead_EAST,
  input  logic                                memRead_WEST,
  input  logic                                memWrite_NORTH,
  input  logic                                memWrite_SOUTH,
  input  logic                                memWrite_EAST,
  input  logic                                memWrite_WEST,
  input  logic [DATA_WIDTH-1:0]               dataIn_NORTH,
  input  logic [DATA_WIDTH-1:0]               dataIn_SOUTH,
  input  logic [DATA_WIDTH-1:0]               dataIn_EAST,
  input  logic [DATA_WIDTH-1:0]               dataIn_WEST,
  output logic                                readReady_NORTH,
  output logic                                readReady_SOUTH,
  output logic                                readReady_EAST,
  output logic                                readReady_WEST,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut_NORTH,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut_SOUTH,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut_EAST,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut_WEST,
  output logic [DATA_WIDTH-1:0]               cacheDataIn,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheWriteAddressIn,
  output logic                                memWrite,
  output logic                                memRead,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheReadAddress_0,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheReadAddress_1,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheReadAddress_2,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheReadAddress_3
);

  localparam int unsigned AW   = CACHE_BANK_ADDRESS_WIDTH;
  localparam int unsigned NW   = NETWORK_ADDRESS_WIDTH;
  localparam int unsigned PtrW = $clog2(WR_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [AW-1:0]         addr_in [4];
  logic [NW-1:0]         req_in  [4];
  logic [DATA_WIDTH-1:0] data_in [4];
  logic [3:0]            rd_req;
  logic [3:0]            wr_req;

  assign addr_in[0] = cacheAddressIn_NORTH;
  assign addr_in[1] = cacheAddressIn_SOUTH;
  assign addr_in[2] = cacheAddressIn_EAST;
  assign addr_in[3] = cacheAddressIn_WEST;
  assign req_in[0]  = requesterAddressIn_NORTH;
  assign req_in[1]  = requesterAddressIn_SOUTH;
  assign req_in[2]  = requesterAddressIn_EAST;
  assign req_in[3]  = requesterAddressIn_WEST;
  assign data_in[0] = dataIn_NORTH;
  assign data_in[1] = dataIn_SOUTH;
  assign data_in[2] = dataIn_EAST;
  assign data_in[3] = dataIn_WEST;
  assign rd_req     = {memRead_WEST, memRead_EAST, memRead_SOUTH, memRead_NORTH};
  assign wr_req     = {memWrite_WEST, memWrite_EAST, memWrite_SOUTH, memWrite_NORTH};

  logic [AW-1:0]         fifo_addr_q [4][WR_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [4][WR_FIFO_DEPTH];
  logic [PtrW-1:0]       rd_ptr_q [4];
  logic [PtrW-1:0]       wr_ptr_q [4];
  logic [CntW-1:0]       count_q  [4];

  logic [3:0] nonempty;
  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] pop;
  logic       grant_valid;
  logic [1:0] grant_idx;

  logic                  mem_write_q;
  logic [AW-1:0]         waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            rd_valid_q;
  logic [3:0]            ready_q;
  logic [AW-1:0]         raddr_q [4];
  logic [NW-1:0]         rq_q    [4];
  logic [NW-1:0]         rqo_q   [4];

`ifdef ARBITER_ROUND_ROBIN_EN
  logic [1:0] rr_q;
  logic [1:0] cand;
`endif

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      nonempty[p] = (count_q[p] != '0);
      full[p]     = (count_q[p] == CntW'(WR_FIFO_DEPTH));
      // Fullness is judged before this edge's pop, so a full FIFO drops even while draining.
      push[p]     = wr_req[p] && !full[p];
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
`ifdef ARBITER_ROUND_ROBIN_EN
    cand = '0;
    for (int i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (nonempty[i]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(i);
      end
    end
`endif
    for (int p = 0; p < 4; p++) begin
      pop[p] = grant_valid && (grant_idx == 2'(p));
    end
  end

  // Storage needs no reset: emptiness is tracked by the counters alone.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (push[p]) begin
        fifo_addr_q[p][wr_ptr_q[p]] <= addr_in[p];
        fifo_data_q[p][wr_ptr_q[p]] <= data_in[p];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_write_q <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rd_valid_q  <= '0;
      ready_q     <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      rr_q        <= '0;
`endif
      for (int p = 0; p < 4; p++) begin
        rd_ptr_q[p] <= '0;
        wr_ptr_q[p] <= '0;
        count_q[p]  <= '0;
        raddr_q[p]  <= '0;
        rq_q[p]     <= '0;
        rqo_q[p]    <= '0;
      end
    end else begin
      mem_write_q <= grant_valid;
      if (grant_valid) begin
        waddr_q <= fifo_addr_q[grant_idx][rd_ptr_q[grant_idx]];
        wdata_q <= fifo_data_q[grant_idx][rd_ptr_q[grant_idx]];
`ifdef ARBITER_ROUND_ROBIN_EN
        rr_q    <= grant_idx + 2'd1;
`endif
      end
      rd_valid_q <= rd_req;
      ready_q    <= rd_valid_q;
      for (int p = 0; p < 4; p++) begin
        if (pop[p]) rd_ptr_q[p] <= rd_ptr_q[p] + PtrW'(1);
        if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PtrW'(1);
        count_q[p] <= count_q[p] + CntW'(push[p]) - CntW'(pop[p]);
        if (rd_req[p]) begin
          raddr_q[p] <= addr_in[p];
          rq_q[p]    <= req_in[p];
        end
        if (rd_valid_q[p]) rqo_q[p] <= rq_q[p];
      end
    end
  end

  assign memWrite                  = mem_write_q;
  assign cacheWriteAddressIn       = waddr_q;
  assign cacheDataIn               = wdata_q;
  assign memRead                   = |rd_valid_q;
  assign cacheReadAddress_0        = raddr_q[0];
  assign cacheReadAddress_1        = raddr_q[1];
  assign cacheReadAddress_2        = raddr_q[2];
  assign cacheReadAddress_3        = raddr_q[3];
  assign readReady_NORTH           = ready_q[0];
  assign readReady_SOUTH           = ready_q[1];
  assign readReady_EAST            = ready_q[2];
  assign readReady_WEST            = ready_q[3];
  assign requesterAddressOut_NORTH = rqo_q[0];
  assign requesterAddressOut_SOUTH = rqo_q[1];
  assign requesterAddressOut_EAST  = rqo_q[2];
  assign requesterAddressOut_WEST  = rqo_q[3];

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Bench for cache_access_arbiter: directed scenarios plus random traffic against a queue model.
module tb_cache_access_arbiter;

  localparam int AW    = 8;
  localparam int NW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0][AW-1:0] ca;
  logic [3:0][NW-1:0] ra;
  logic [3:0][DW-1:0] di;
  logic [3:0]         mr;
  logic [3:0]         mw;

  logic [3:0]         ready;
  logic [3:0][NW-1:0] rqo;
  logic [3:0][AW-1:0] rda;
  logic [DW-1:0]      cdata;
  logic [AW-1:0]      cwaddr;
  logic               bmw;
  logic               bmr;

  cache_access_arbiter #(
    .CACHE_BANK_ADDRESS_WIDTH(AW),
    .NETWORK_ADDRESS_WIDTH   (NW),
    .DATA_WIDTH              (DW),
    .WR_FIFO_DEPTH           (DEPTH)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .cacheAddressIn_NORTH     (ca[0]),
    .cacheAddressIn_SOUTH     (ca[1]),
    .cacheAddressIn_EAST      (ca[2]),
    .cacheAddressIn_WEST      (ca[3]),
    .requesterAddressIn_NORTH (ra[0]),
    .requesterAddressIn_SOUTH (ra[1]),
    .requesterAddressIn_EAST  (ra[2]),
    .requesterAddressIn_WEST  (ra[3]),
    .memRead_NORTH            (mr[0]),
    .memRead_SOUTH            (mr[1]),
    .memRead_EAST             (mr[2]),
    .memRead_WEST             (mr[3]),
    .memWrite_NORTH           (mw[0]),
    .memWrite_SOUTH           (mw[1]),
    .memWrite_EAST            (mw[2]),
    .memWrite_WEST            (mw[3]),
    .dataIn_NORTH             (di[0]),
    .dataIn_SOUTH             (di[1]),
    .dataIn_EAST              (di[2]),
    .dataIn_WEST              (di[3]),
    .readReady_NORTH          (ready[0]),
    .readReady_SOUTH          (ready[1]),
    .readReady_EAST           (ready[2]),
    .readReady_WEST           (ready[3]),
    .requesterAddressOut_NORTH(rqo[0]),
    .requesterAddressOut_SOUTH(rqo[1]),
    .requesterAddressOut_EAST (rqo[2]),
    .requesterAddressOut_WEST (rqo[3]),
    .cacheDataIn              (cdata),
    .cacheWriteAddressIn      (cwaddr),
    .memWrite                 (bmw),
    .memRead                  (bmr),
    .cacheReadAddress_0       (rda[0]),
    .cacheReadAddress_1       (rda[1]),
    .cacheReadAddress_2       (rda[2]),
    .cacheReadAddress_3       (rda[3])
  );

  // Reference model: one queue of pending {addr, data} writes per port.
  bit   [AW+DW-1:0] wq [4][$];
  logic             exp_mw;
  logic [AW-1:0]    exp_waddr;
  logic [DW-1:0]    exp_wdata;
  logic [3:0]       rv;
  logic [NW-1:0]    rq      [4];
  logic [3:0]       exp_ready;
  logic [NW-1:0]    exp_rqo [4];
  logic [AW-1:0]    exp_rda [4];
  int               rr_ptr;

  int errors = 0;
  int checks = 0;
  int pulses;
  logic [AW-1:0] seen [8];

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      wq[p].delete();
      rq[p]      = '0;
      exp_rqo[p] = '0;
      exp_rda[p] = '0;
    end
    exp_mw = 1'b0; exp_waddr = '0; exp_wdata = '0;
    rv = '0; exp_ready = '0; rr_ptr = 0;
  endtask

  task automatic model_edge();
    bit [3:0] is_full;
    int g;
    bit [AW+DW-1:0] ent;
    g = -1;
    for (int p = 0; p < 4; p++) is_full[p] = (wq[p].size() >= DEPTH);
`ifdef ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++)
      if (g < 0 && wq[(rr_ptr + k) % 4].size() > 0) g = (rr_ptr + k) % 4;
`else
    for (int p = 0; p < 4; p++)
      if (g < 0 && wq[p].size() > 0) g = p;
`endif
    if (g >= 0) begin
      ent       = wq[g].pop_front();
      exp_mw    = 1'b1;
      exp_waddr = ent[AW+DW-1:DW];
      exp_wdata = ent[DW-1:0];
      rr_ptr    = (g + 1) % 4;
    end else begin
      exp_mw = 1'b0;
    end
    for (int p = 0; p < 4; p++)
      if (mw[p] && !is_full[p]) wq[p].push_back({ca[p], di[p]});
    for (int p = 0; p < 4; p++) begin
      exp_ready[p] = rv[p];
      if (rv[p]) exp_rqo[p] = rq[p];
      rv[p] = mr[p];
      if (mr[p]) begin
        exp_rda[p] = ca[p];
        rq[p]      = ra[p];
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("memWrite", 64'(bmw), 64'(exp_mw));
    check("cacheWriteAddressIn", 64'(cwaddr), 64'(exp_waddr));
    check("cacheDataIn", 64'(cdata), 64'(exp_wdata));
    check("memRead", 64'(bmr), 64'(|rv));
    for (int p = 0; p < 4; p++) begin
      check($sformatf("readReady[%0d]", p), 64'(ready[p]), 64'(exp_ready[p]));
      check($sformatf("requesterAddressOut[%0d]", p), 64'(rqo[p]), 64'(exp_rqo[p]));
      check($sformatf("cacheReadAddress_%0d", p), 64'(rda[p]), 64'(exp_rda[p]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic idle();
    mr = '0;
    mw = '0;
  endtask

  task automatic randomize_inputs(input int wr_odds);
    for (int p = 0; p < 4; p++) begin
      ca[p] = AW'($urandom);
      ra[p] = NW'($urandom);
      di[p] = DW'($urandom);
      mr[p] = 1'($urandom_range(0, 1));
      mw[p] = ($urandom_range(0, wr_odds) == 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    ca = '0; ra = '0; di = '0;
    idle();
    model_reset();
    #1;
    check_all();

    // Inputs toggle under reset; outputs must stay zero.
    repeat (5) begin
      randomize_inputs(1);
      step();
    end
    idle();
    reset = 1'b1;
    repeat (3) step();

    // Single NORTH write.
    ca[0] = 8'h02; di[0] = 32'd10; mw[0] = 1'b1;
    step();
    idle();
    step();
    check("n_write_en", 64'(bmw), 64'd1);
    check("n_write_addr", 64'(cwaddr), 64'h02);
    check("n_write_data", 64'(cdata), 64'd10);
    step();
    check("n_write_drop", 64'(bmw), 64'd0);

    // NORTH and SOUTH together.
    ca[0] = 8'h03; di[0] = 32'd5; mw[0] = 1'b1;
    ca[1] = 8'h01; di[1] = 32'd4; mw[1] = 1'b1;
    step();
    idle();
    step();
`ifndef ARBITER_ROUND_ROBIN_EN
    check("ns_first_addr", 64'(cwaddr), 64'h03);
    check("ns_first_data", 64'(cdata), 64'd5);
`endif
    step();
`ifndef ARBITER_ROUND_ROBIN_EN
    check("ns_second_addr", 64'(cwaddr), 64'h01);
    check("ns_second_data", 64'(cdata), 64'd4);
`endif
    step();
    check("ns_drop", 64'(bmw), 64'd0);

    // SOUTH, EAST, WEST together.
    ca[1] = 8'h09; di[1] = 32'd9; mw[1] = 1'b1;
    ca[2] = 8'h05; di[2] = 32'd6; mw[2] = 1'b1;
    ca[3] = 8'h04; di[3] = 32'd7; mw[3] = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sew_en%0d", i), 64'(bmw), 64'd1);
`ifndef ARBITER_ROUND_ROBIN_EN
      seen[i] = cwaddr;
`endif
    end
`ifndef ARBITER_ROUND_ROBIN_EN
    check("sew_order0", 64'(seen[0]), 64'h09);
    check("sew_order1", 64'(seen[1]), 64'h05);
    check("sew_order2", 64'(seen[2]), 64'h04);
`endif
    step();

    // Parallel reads on NORTH and WEST.
    ca[0] = 8'h20; ra[0] = 6'd3; mr[0] = 1'b1;
    ca[3] = 8'h40; ra[3] = 6'd5; mr[3] = 1'b1;
    step();
    idle();
    check("rd_addr0", 64'(rda[0]), 64'h20);
    check("rd_addr3", 64'(rda[3]), 64'h40);
    check("rd_memread", 64'(bmr), 64'd1);
    step();
    check("rd_ready", 64'(ready), 64'b1001);
    check("rd_req0", 64'(rqo[0]), 64'd3);
    check("rd_req3", 64'(rqo[3]), 64'd5);
    step();
    check("rd_ready_drop", 64'(ready), 64'b0000);
    check("rd_req_hold", 64'(rqo[3]), 64'd5);

    // WEST overflows while NORTH keeps the write port busy.
    for (int i = 0; i < 5; i++) begin
      ca[0] = AW'(8'h10 + i); di[0] = DW'(100 + i); mw[0] = 1'b1;
      ca[3] = AW'(8'h30 + i); di[3] = DW'(200 + i); mw[3] = 1'b1;
      step();
    end
    idle();
    pulses = 0;
    repeat (8) begin
      step();
      if (bmw) begin
        seen[pulses] = cwaddr;
        pulses++;
      end
    end
`ifndef ARBITER_ROUND_ROBIN_EN
    check("drain_pulses", 64'(pulses), 64'd5);
    for (int i = 0; i < 4; i++)
      check($sformatf("drain_west%0d", i), 64'(seen[i + 1]), 64'(8'h30 + i));
`endif

    // Refill, then reset mid-drain.
    for (int i = 0; i < 4; i++) begin
      ca[0] = AW'(8'h50 + i); di[0] = DW'(i); mw[0] = 1'b1;
      ca[3] = AW'(8'h60 + i); di[3] = DW'(i); mw[3] = 1'b1;
      step();
    end
    idle();
    repeat (2) step();
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_reset_memwrite", 64'(bmw), 64'd0);
    check_all();
    repeat (2) step();
    reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      step();
      if (bmw) pulses++;
    end
    check("post_reset_pulses", 64'(pulses), 64'd0);

    // Random traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      randomize_inputs(2);
      if (c == 200) begin
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        reset = 1'b1;
      end
      step();
    end
    idle();
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
